// File: rtl/tank_move_checker_if.sv
// Request/response and map-RAM read bus between tank control, the move checker and the tile map RAM.
// The slave modport is the checker. The master modport is the requester plus the RAM side.
interface tank_move_checker_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic [8:0]        Req_X;
  logic [8:0]        Req_Y;
  logic              map_rd_en;
  logic [ADDR_W-1:0] map_addr;
  logic [2:0]        map_rdata;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_blocked;
  logic [4:0]        resp_col;
  logic [4:0]        resp_row;

  modport slave (
    input  req_valid, Req_X, Req_Y, map_rdata, resp_ready,
    output req_ready, map_rd_en, map_addr, resp_valid, resp_blocked, resp_col, resp_row
  );

  modport master (
    output req_valid, Req_X, Req_Y, map_rdata, resp_ready,
    input  req_ready, map_rd_en, map_addr, resp_valid, resp_blocked, resp_col, resp_row
  );
endinterface

// File: rtl/tank_move_checker.sv
// Collision query engine: scans every map tile under a proposed 16x16 tank footprint,
// one RAM read per cycle, and reports blocked/clear plus the first blocking tile.
module tank_move_checker #(
  parameter int TANK_SIZE = 16,
  parameter int TILE_SIZE = 8,
  parameter int MAP_COLS  = 26,
  parameter int MAP_ROWS  = 26,
  parameter int FIELD_W   = 208,
  parameter int FIELD_H   = 208,
  parameter int ADDR_W    = 10
) (
  input  logic Clk,
  input  logic Reset,
  tank_move_checker_if.slave bus
);

  localparam int TILE_SH = $clog2(TILE_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        c0_q, c0_d;
  logic [4:0]        c1_q, c1_d;
  logic [4:0]        r1_q, r1_d;
  logic [4:0]        rd_col_q, rd_col_d;
  logic [4:0]        rd_row_q, rd_row_d;
  logic [4:0]        chk_col_q, chk_col_d;
  logic [4:0]        chk_row_q, chk_row_d;
  logic              data_vld_q, data_vld_d;
  logic              map_rd_en_q, map_rd_en_d;
  logic [ADDR_W-1:0] map_addr_q, map_addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_blocked_q, resp_blocked_d;
  logic [4:0]        resp_col_q, resp_col_d;
  logic [4:0]        resp_row_q, resp_row_d;

  logic [9:0]        x_end_s;
  logic [9:0]        y_end_s;
  logic              out_of_field_s;
  logic [4:0]        x_c0_s, x_c1_s, y_r0_s, y_r1_s;
  logic              hit_s;
  logic              last_s;
  logic [4:0]        nxt_col_s, nxt_row_s;

  function automatic logic [ADDR_W-1:0] tile_addr(input logic [4:0] row, input logic [4:0] col);
    logic [ADDR_W-1:0] row_w;
    row_w = ADDR_W'(row);
    return (row_w * ADDR_W'(MAP_COLS)) + ADDR_W'(col);
  endfunction

  // X+TANK_SIZE > FIELD_W is evaluated as X+TANK_SIZE-1 >= FIELD_W so the same sum yields the last tile.
  assign x_end_s        = {1'b0, bus.Req_X} + 10'(TANK_SIZE - 1);
  assign y_end_s        = {1'b0, bus.Req_Y} + 10'(TANK_SIZE - 1);
  assign out_of_field_s = (x_end_s >= 10'(FIELD_W)) || (y_end_s >= 10'(FIELD_H));
  assign x_c0_s         = 5'(bus.Req_X >> TILE_SH);
  assign y_r0_s         = 5'(bus.Req_Y >> TILE_SH);
  assign x_c1_s         = 5'(x_end_s >> TILE_SH);
  assign y_r1_s         = 5'(y_end_s >> TILE_SH);

  assign hit_s     = data_vld_q && (bus.map_rdata < 3'd3);
  assign last_s    = (rd_col_q == c1_q) && (rd_row_q == r1_q);
  assign nxt_col_s = (rd_col_q == c1_q) ? c0_q : (rd_col_q + 5'd1);
  assign nxt_row_s = (rd_col_q == c1_q) ? (rd_row_q + 5'd1) : rd_row_q;

  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.map_rd_en    = map_rd_en_q;
  assign bus.map_addr     = map_addr_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_blocked = resp_blocked_q;
  assign bus.resp_col     = resp_col_q;
  assign bus.resp_row     = resp_row_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      c0_q           <= 5'd0;
      c1_q           <= 5'd0;
      r1_q           <= 5'd0;
      rd_col_q       <= 5'd0;
      rd_row_q       <= 5'd0;
      chk_col_q      <= 5'd0;
      chk_row_q      <= 5'd0;
      data_vld_q     <= 1'b0;
      map_rd_en_q    <= 1'b0;
      map_addr_q     <= '0;
      resp_valid_q   <= 1'b0;
      resp_blocked_q <= 1'b0;
      resp_col_q     <= 5'd0;
      resp_row_q     <= 5'd0;
    end else begin
      state_q        <= state_d;
      c0_q           <= c0_d;
      c1_q           <= c1_d;
      r1_q           <= r1_d;
      rd_col_q       <= rd_col_d;
      rd_row_q       <= rd_row_d;
      chk_col_q      <= chk_col_d;
      chk_row_q      <= chk_row_d;
      data_vld_q     <= data_vld_d;
      map_rd_en_q    <= map_rd_en_d;
      map_addr_q     <= map_addr_d;
      resp_valid_q   <= resp_valid_d;
      resp_blocked_q <= resp_blocked_d;
      resp_col_q     <= resp_col_d;
      resp_row_q     <= resp_row_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    c0_d           = c0_q;
    c1_d           = c1_q;
    r1_d           = r1_q;
    rd_col_d       = rd_col_q;
    rd_row_d       = rd_row_q;
    chk_col_d      = chk_col_q;
    chk_row_d      = chk_row_q;
    data_vld_d     = data_vld_q;
    map_rd_en_d    = map_rd_en_q;
    map_addr_d     = map_addr_q;
    resp_valid_d   = resp_valid_q;
    resp_blocked_d = resp_blocked_q;
    resp_col_d     = resp_col_q;
    resp_row_d     = resp_row_q;

    case (state_q)
      ST_IDLE: begin
        data_vld_d  = 1'b0;
        map_rd_en_d = 1'b0;
        if (bus.req_valid) begin
          if (out_of_field_s) begin
            state_d        = ST_RESP;
            resp_valid_d   = 1'b1;
            resp_blocked_d = 1'b1;
            resp_col_d     = 5'd31;
            resp_row_d     = 5'd31;
          end else begin
            state_d     = ST_SCAN;
            c0_d        = x_c0_s;
            c1_d        = x_c1_s;
            r1_d        = y_r1_s;
            rd_col_d    = x_c0_s;
            rd_row_d    = y_r0_s;
            map_addr_d  = tile_addr(y_r0_s, x_c0_s);
            map_rd_en_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      // Each cycle checks the data of the previous read while issuing the next one.
      ST_SCAN: begin
        if (hit_s) begin
          state_d        = ST_RESP;
          map_rd_en_d    = 1'b0;
          data_vld_d     = 1'b0;
          resp_valid_d   = 1'b1;
          resp_blocked_d = 1'b1;
          resp_col_d     = chk_col_q;
          resp_row_d     = chk_row_q;
        end else begin
          chk_col_d  = rd_col_q;
          chk_row_d  = rd_row_q;
          data_vld_d = 1'b1;
          if (last_s) begin
            state_d     = ST_DRAIN;
            map_rd_en_d = 1'b0;
          end else begin
            rd_col_d    = nxt_col_s;
            rd_row_d    = nxt_row_s;
            map_addr_d  = tile_addr(nxt_row_s, nxt_col_s);
            map_rd_en_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        state_d      = ST_RESP;
        data_vld_d   = 1'b0;
        map_rd_en_d  = 1'b0;
        resp_valid_d = 1'b1;
        if (hit_s) begin
          resp_blocked_d = 1'b1;
          resp_col_d     = chk_col_q;
          resp_row_d     = chk_row_q;
        end else begin
          resp_blocked_d = 1'b0;
          resp_col_d     = 5'd0;
          resp_row_d     = 5'd0;
        end
      end

      ST_RESP: begin
        map_rd_en_d = 1'b0;
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        data_vld_d   = 1'b0;
        map_rd_en_d  = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tank_move_checker.sv
// Self-checking bench for tank_move_checker: table of directed queries, hand-written
// backpressure and mid-scan reset sequences, then random maps/positions against a tile-walk model.
module tb_tank_move_checker;

  logic Clk;
  logic Reset;
  int   total;
  int   bad;

  logic [2:0] mem [0:675];
  int         got_addr[$];
  int         exp_addr[$];

  tank_move_checker_if #(.ADDR_W(10)) bus_if ();

  tank_move_checker dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Map RAM: one-cycle read latency.
  always @(posedge Clk) begin
    if (bus_if.map_rd_en) begin
      if (bus_if.map_addr < 10'd676) bus_if.map_rdata <= mem[bus_if.map_addr];
      else                           bus_if.map_rdata <= 3'd7;
    end
  end

  typedef struct {
    int x; int y;
    int ob_en; int ob_col; int ob_row; int ob_id;
    int e_blk; int e_col; int e_row; int e_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_map(input int id);
    for (int i = 0; i < 676; i++) mem[i] = 3'(id);
  endtask

  // Reference: walk the footprint tile by tile; a hit lets one more (discarded) read through.
  task automatic model(input int x, input int y,
                       output int blk, output int col, output int row, output int lat);
    int n;
    int found;
    int extra;
    exp_addr.delete();
    blk = 0; col = 0; row = 0;
    if (x + 16 > 208 || y + 16 > 208) begin
      blk = 1; col = 31; row = 31; lat = 1;
    end else begin
      n = 0; found = 0; extra = 0;
      for (int r = y / 8; r <= (y + 15) / 8; r++) begin
        for (int c = x / 8; c <= (x + 15) / 8; c++) begin
          if (found == 0) begin
            n++;
            exp_addr.push_back(r * 26 + c);
            if (mem[r * 26 + c] < 3'd3) begin
              found = 1; blk = 1; col = c; row = r;
            end
          end else if (extra == 0) begin
            extra = 1;
            exp_addr.push_back(r * 26 + c);
          end
        end
      end
      lat = n + 2;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Issue a query, record reads and latency, then complete the handshake after hold_cycles.
  task automatic run_query(input int x, input int y, input int hold_cycles,
                           output int lat, output int blk, output int col, output int row);
    lat = 0; blk = -1; col = -1; row = -1;
    got_addr.delete();
    @(negedge Clk);
    bus_if.Req_X     = 9'(x);
    bus_if.Req_Y     = 9'(y);
    bus_if.req_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus_if.req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge Clk);
      if (bus_if.map_rd_en) got_addr.push_back(int'(bus_if.map_addr));
      if (bus_if.resp_valid) begin
        lat = cyc;
        blk = int'(bus_if.resp_blocked);
        col = int'(bus_if.resp_col);
        row = int'(bus_if.resp_row);
        break;
      end
    end
    if (lat == 0) begin
      check("resp_timeout", 0, 1);
      do_reset();
    end else begin
      repeat (hold_cycles) @(negedge Clk);
      bus_if.resp_ready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      bus_if.resp_ready = 1'b0;
      check("after_hs_resp_valid", int'(bus_if.resp_valid), 0);
      check("after_hs_req_ready", int'(bus_if.req_ready), 1);
    end
  endtask

  task automatic compare_addrs(input string tag);
    check({tag, "_nreads"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
  endtask

  initial begin
    int lat, blk, col, row;
    int mlat, mblk, mcol, mrow;
    total = 0; bad = 0;
    bus_if.req_valid  = 1'b0;
    bus_if.resp_ready = 1'b0;
    bus_if.Req_X      = 9'd0;
    bus_if.Req_Y      = 9'd0;
    fill_map(4);
    do_reset();

    check("rst_req_ready", int'(bus_if.req_ready), 1);
    check("rst_resp_valid", int'(bus_if.resp_valid), 0);
    check("rst_blocked", int'(bus_if.resp_blocked), 0);
    check("rst_col", int'(bus_if.resp_col), 0);
    check("rst_row", int'(bus_if.resp_row), 0);
    check("rst_rd_en", int'(bus_if.map_rd_en), 0);
    check("rst_addr", int'(bus_if.map_addr), 0);

    //         x    y  ob  col row id  blk col row lat
    vecs[0]  = '{16,  16, 0,  0,  0, 0,  0,  0,  0,  6};
    vecs[1]  = '{20,  20, 0,  0,  0, 0,  0,  0,  0, 11};
    vecs[2]  = '{20,  16, 1,  3,  2, 1,  1,  3,  2,  4};
    vecs[3]  = '{200,  0, 0,  0,  0, 0,  1, 31, 31,  1};
    vecs[4]  = '{192,192, 0,  0,  0, 0,  0,  0,  0,  6};
    vecs[5]  = '{192,192, 1, 25, 25, 2,  1, 25, 25,  6};
    vecs[6]  = '{0,    0, 1,  0,  0, 3,  0,  0,  0,  6};
    vecs[7]  = '{0,    0, 1,  1,  1, 0,  1,  1,  1,  6};
    vecs[8]  = '{193,  0, 0,  0,  0, 0,  1, 31, 31,  1};
    vecs[9]  = '{0,  193, 0,  0,  0, 0,  1, 31, 31,  1};
    vecs[10] = '{4,    4, 1,  0,  0, 0,  1,  0,  0,  3};

    for (int v = 0; v < 11; v++) begin
      fill_map(4);
      if (vecs[v].ob_en != 0) mem[vecs[v].ob_row * 26 + vecs[v].ob_col] = 3'(vecs[v].ob_id);
      model(vecs[v].x, vecs[v].y, mblk, mcol, mrow, mlat);
      run_query(vecs[v].x, vecs[v].y, v % 3, lat, blk, col, row);
      check($sformatf("v%0d_lat", v), lat, vecs[v].e_lat);
      check($sformatf("v%0d_blk", v), blk, vecs[v].e_blk);
      check($sformatf("v%0d_col", v), col, vecs[v].e_col);
      check($sformatf("v%0d_row", v), row, vecs[v].e_row);
      compare_addrs($sformatf("v%0d", v));
    end

    // Backpressure: response held with a new request pending, accepted only after handshake.
    fill_map(4);
    mem[2 * 26 + 3] = 3'd1;
    @(negedge Clk);
    bus_if.Req_X = 9'd20; bus_if.Req_Y = 9'd16; bus_if.req_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus_if.Req_X = 9'd200; bus_if.Req_Y = 9'd0;
    repeat (3) @(negedge Clk);
    check("bp_resp_valid_at4", int'(bus_if.resp_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check($sformatf("bp_hold%0d_valid", i), int'(bus_if.resp_valid), 1);
      check($sformatf("bp_hold%0d_blk", i), int'(bus_if.resp_blocked), 1);
      check($sformatf("bp_hold%0d_col", i), int'(bus_if.resp_col), 3);
      check($sformatf("bp_hold%0d_row", i), int'(bus_if.resp_row), 2);
      check($sformatf("bp_hold%0d_ready", i), int'(bus_if.req_ready), 0);
    end
    bus_if.resp_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus_if.resp_ready = 1'b0;
    check("bp_hs_req_ready", int'(bus_if.req_ready), 1);
    check("bp_hs_resp_valid", int'(bus_if.resp_valid), 0);
    @(posedge Clk);
    @(negedge Clk);
    bus_if.req_valid = 1'b0;
    check("bp_next_resp_valid", int'(bus_if.resp_valid), 1);
    check("bp_next_col", int'(bus_if.resp_col), 31);
    check("bp_next_req_ready", int'(bus_if.req_ready), 0);
    bus_if.resp_ready = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus_if.resp_ready = 1'b0;

    // Reset during a 9-tile scan aborts it with no response.
    fill_map(4);
    @(negedge Clk);
    bus_if.Req_X = 9'd20; bus_if.Req_Y = 9'd20; bus_if.req_valid = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    bus_if.req_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rs_rd_en_before", int'(bus_if.map_rd_en), 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("rs_rd_en", int'(bus_if.map_rd_en), 0);
    check("rs_resp_valid", int'(bus_if.resp_valid), 0);
    check("rs_req_ready", int'(bus_if.req_ready), 1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge Clk);
        if (bus_if.resp_valid || bus_if.map_rd_en) seen = 1;
      end
      check("rs_no_response", seen, 0);
    end

    // Random maps and positions against the model.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 676; i++) begin
        if ($urandom_range(0, 9) == 0) mem[i] = 3'($urandom_range(0, 2));
        else                           mem[i] = 3'($urandom_range(3, 7));
      end
      begin
        int rx, ry;
        rx = $urandom_range(0, 215);
        ry = $urandom_range(0, 215);
        model(rx, ry, mblk, mcol, mrow, mlat);
        run_query(rx, ry, $urandom_range(0, 3), lat, blk, col, row);
        check($sformatf("r%0d_lat", t), lat, mlat);
        check($sformatf("r%0d_blk", t), blk, mblk);
        check($sformatf("r%0d_col", t), col, mcol);
        check($sformatf("r%0d_row", t), row, mrow);
        compare_addrs($sformatf("r%0d", t));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
